vga_timing_gen: RTL and testbench

// - Raster timing source for the 1440x900@60 display path. Free-running H/V pixel

---
 rtl/vga_timing_gen.sv | 143 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing source (pixel counters, sync
// pulses, active-video flag, line/frame strobes, 6-bit frame counter).
// Optional feature macro: VGA_LOOKAHEAD_EN -- delays the decoded outputs
// (hsync, vsync, active, line_start, frame_start) by LOOKAHEAD cycles so that
// pos_x/pos_y/count lead them, hiding downstream renderer latency.
module vga_timing_gen #(
  parameter int       H_ACTIVE  = 1440,
  parameter int       H_FP      = 80,
  parameter int       H_SYNC    = 152,
  parameter int       H_BP      = 232,
  parameter int       V_ACTIVE  = 900,
  parameter int       V_FP      = 1,
  parameter int       V_SYNC    = 3,
  parameter int       V_BP      = 28,
  parameter logic     H_POL     = 1'b0,
  parameter logic     V_POL     = 1'b1,
  parameter int       LOOKAHEAD = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] pos_x,
  output logic [10:0] pos_y,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic [5:0]  count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters and comparators are 11 bits wide; refuse configurations that overflow.
  generate
    if (H_TOTAL >= 2048 || V_TOTAL >= 2048) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be below 2048");
    end
    if (LOOKAHEAD < 1) begin : g_bad_lookahead
      $error("vga_timing_gen: LOOKAHEAD must be at least 1");
    end
  endgenerate

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Decoded bundle ordering: {hsync, vsync, active, line_start, frame_start}
  localparam logic [4:0] DEC_IDLE = {~H_POL, ~V_POL, 3'b000};

  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [5:0]  r_cnt;
  logic [4:0]  r_dec;

  logic [10:0] w_x_next;
  logic [10:0] w_y_next;
  logic [5:0]  w_cnt_next;
  logic [4:0]  w_dec_next;

  // Next-state counters; reset forces the origin so decode below yields the reset outputs.
  always_comb begin
    w_x_next   = r_x + 11'd1;
    w_y_next   = r_y;
    w_cnt_next = r_cnt;
    if (r_x == H_LAST) begin
      w_x_next = 11'd0;
      if (r_y == V_LAST) begin
        w_y_next   = 11'd0;
        w_cnt_next = r_cnt + 6'd1;
      end else begin
        w_y_next = r_y + 11'd1;
      end
    end
    if (rst) begin
      w_x_next   = 11'd0;
      w_y_next   = 11'd0;
      w_cnt_next = 6'd0;
    end
  end

  // Decode from the next-state counters so registered outputs line up with pos.
  always_comb begin
    w_dec_next = DEC_IDLE;
    if (w_x_next >= HS_START && w_x_next < HS_END) begin
      w_dec_next[4] = H_POL;
    end
    if (w_y_next >= VS_START && w_y_next < VS_END) begin
      w_dec_next[3] = V_POL;
    end
    w_dec_next[2] = (w_x_next < H_ACT_END) && (w_y_next < V_ACT_END);
    w_dec_next[1] = (w_x_next == 11'd0);
    w_dec_next[0] = (w_x_next == 11'd0) && (w_y_next == 11'd0);
  end

  // Counter and aligned-decode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= 11'd0;
      r_y   <= 11'd0;
      r_cnt <= 6'd0;
      r_dec <= {~H_POL, ~V_POL, 3'b111};
    end else begin
      r_x   <= w_x_next;
      r_y   <= w_y_next;
      r_cnt <= w_cnt_next;
      r_dec <= w_dec_next;
    end
  end

  assign pos_x = r_x;
  assign pos_y = r_y;
  assign count = r_cnt;

`ifdef VGA_LOOKAHEAD_EN
  logic [4:0] r_pipe [LOOKAHEAD];

  generate
    for (genvar gi = 0; gi < LOOKAHEAD; gi++) begin : g_pipe
      // Delay stage gi of the decoded bundle; stages restart idle on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pipe[gi] <= DEC_IDLE;
        end else if (gi == 0) begin
          r_pipe[gi] <= r_dec;
        end else begin
          r_pipe[gi] <= r_pipe[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign {hsync, vsync, active, line_start, frame_start} = r_pipe[LOOKAHEAD-1];
`else
  assign {hsync, vsync, active, line_start, frame_start} = r_dec;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster so that many
// whole frames (including the 64-frame counter wrap) fit in a short run.
module tb_vga_timing_gen;

  localparam int   HA = 20, HF = 4, HS = 6, HB = 5;
  localparam int   VA = 10, VF = 1, VS = 3, VB = 2;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FRAME = HT * VT;
  localparam bit   HPOL = 1'b0;
  localparam bit   VPOL = 1'b1;
  localparam int   LA = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] pos_x, pos_y;
  logic        hsync, vsync, active, line_start, frame_start;
  logic [5:0]  count;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HPOL), .V_POL(VPOL), .LOOKAHEAD(LA)
  ) dut (
    .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
    .hsync(hsync), .vsync(vsync), .active(active),
    .line_start(line_start), .frame_start(frame_start), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, cnt;
    bit hs, vs, act, ls, fs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   t = 0;
  int   fs_pulses = 0;

  // Reference: everything follows from t, the number of edges since reset.
  function automatic exp_t model(input int tt);
    exp_t e;
    int   td;
    e.x   = tt % HT;
    e.y   = (tt / HT) % VT;
    e.cnt = (tt / FRAME) % 64;
`ifdef VGA_LOOKAHEAD_EN
    td = tt - LA;
`else
    td = tt;
`endif
    if (td < 0) begin
      e.hs = ~HPOL; e.vs = ~VPOL; e.act = 0; e.ls = 0; e.fs = 0;
    end else begin
      int dx, dy;
      dx = td % HT;
      dy = (td / HT) % VT;
      e.hs  = (dx >= HA + HF && dx < HA + HF + HS) ? HPOL : ~HPOL;
      e.vs  = (dy >= VA + VF && dy < VA + VF + VS) ? VPOL : ~VPOL;
      e.act = (dx < HA) && (dy < VA);
      e.ls  = (dx == 0);
      e.fs  = (dx == 0) && (dy == 0);
    end
    return e;
  endfunction

  task automatic step(input logic r);
    rst = r;
    if (r) t = 0;
    else   t = t + 1;
    exp_q.push_back(model(t));
    @(negedge clk);
  endtask

  // Monitor: one transaction per clock edge, popped and compared here.
  initial begin : monitor
    int mon_cyc;
    int last_fs;
    exp_t e;
    mon_cyc = 0;
    last_fs = -1;
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pos_x !== 11'(e.x) || pos_y !== 11'(e.y) || count !== 6'(e.cnt) ||
            hsync !== e.hs || vsync !== e.vs || active !== e.act ||
            line_start !== e.ls || frame_start !== e.fs) begin
          failures++;
          if (failures <= 30)
            $display("FAIL sb cyc=%0d got x=%0d y=%0d cnt=%0d hs=%b vs=%b act=%b ls=%b fs=%b exp x=%0d y=%0d cnt=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
                     mon_cyc, pos_x, pos_y, count, hsync, vsync, active, line_start, frame_start,
                     e.x, e.y, e.cnt, e.hs, e.vs, e.act, e.ls, e.fs);
        end
      end
      if (rst) begin
        last_fs   = -1;
        fs_pulses = 0;
      end else if (frame_start === 1'b1) begin
        fs_pulses++;
        if (last_fs >= 0) begin
          checks++;
          if (mon_cyc - last_fs != FRAME) begin
            failures++;
            $display("FAIL fs_period got=%0d exp=%0d", mon_cyc - last_fs, FRAME);
          end
        end
        last_fs = mon_cyc;
      end
    end
  end

  // Stimulus: reset, 64 full frames, random run/reset bursts, mid-frame reset.
  initial begin : stimulus
    int n;
    rst = 1'b1;
    repeat (3) step(1'b1);
    repeat (64 * FRAME) step(1'b0);
    checks++;
    if (fs_pulses != 64) begin
      failures++;
      $display("FAIL fs_count got=%0d exp=%0d", fs_pulses, 64);
    end
    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(1, 2 * FRAME);
      repeat (n) step(1'b0);
      n = $urandom_range(1, 3);
      repeat (n) step(1'b1);
    end
    repeat (5 * FRAME + 7 * HT + 17) step(1'b0);
    step(1'b1);
    repeat (10) step(1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=%0d", exp_q.size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
